// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants, types and helpers for the RGB -> BT.601 YCbCr converter.
package rgb2ycbcr_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned SUM_W = 18;
    localparam int unsigned EXT_W = 10;

    localparam int K_YR = 66;
    localparam int K_YG = 129;
    localparam int K_YB = 25;
    localparam int K_BR = -38;
    localparam int K_BG = -74;
    localparam int K_BB = 112;
    localparam int K_RR = 112;
    localparam int K_RG = -94;
    localparam int K_RB = -18;

    localparam int Y_OFF = 16;
    localparam int C_OFF = 128;
    localparam int RND   = 128;

    localparam int Y_MIN = 16;
    localparam int Y_MAX = 235;
    localparam int C_MIN = 16;
    localparam int C_MAX = 240;

    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic signed [EXT_W-1:0] ext_t;

    typedef struct packed {
        logic [PIX_W-1:0] y;
        logic [PIX_W-1:0] cb;
        logic [PIX_W-1:0] cr;
    } ycc_t;

    // Constant multiply built from shifted copies of x; k folds at elaboration.
    function automatic sum_t cmul(input logic [PIX_W-1:0] x, input int k);
        sum_t acc;
        int   m;
        acc = '0;
        m   = (k < 0) ? -k : k;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) acc = acc + (SUM_W'(x) << i);
        end
        return (k < 0) ? -acc : acc;
    endfunction

    function automatic logic [PIX_W-1:0] sat(input ext_t v, input int lo, input int hi);
        if (v < EXT_W'(lo)) return PIX_W'(lo);
        if (v > EXT_W'(hi)) return PIX_W'(hi);
        return PIX_W'(v);
    endfunction

endpackage

// File: rtl/rgb2ycbcr_dot.sv
// Combinational 3-term constant dot product with the rounding offset added.
module rgb2ycbcr_dot
    import rgb2ycbcr_pkg::*;
#(
    parameter int KA = 0,
    parameter int KB = 0,
    parameter int KC = 0
) (
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    output sum_t             sum
);

    assign sum = cmul(a, KA) + cmul(b, KB) + cmul(c, KC) + SUM_W'(RND);

endmodule

// File: rtl/rgb2ycbcr_pipe.sv
// 2-stage RGB -> BT.601 studio-swing YCbCr converter with valid/ready on both sides.
// Optional 4:2:2 horizontal chroma averaging when CHROMA_422_EN is defined.
module rgb2ycbcr_pipe
    import rgb2ycbcr_pkg::*;
#(
    parameter int unsigned CLAMP_STUDIO = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [PIX_W-1:0] r,
    input  logic [PIX_W-1:0] g,
    input  logic [PIX_W-1:0] b,
    input  logic             sol_i,
    input  logic             vld_i,
    output logic             rdy_o,
    output logic [PIX_W-1:0] y,
    output logic [PIX_W-1:0] cb,
    output logic [PIX_W-1:0] cr,
    output logic             c_vld_o,
    output logic             vld_o,
    input  logic             rdy_i
);

    localparam int Y_LO = (CLAMP_STUDIO != 0) ? Y_MIN : 0;
    localparam int Y_HI = (CLAMP_STUDIO != 0) ? Y_MAX : 255;
    localparam int C_LO = (CLAMP_STUDIO != 0) ? C_MIN : 0;
    localparam int C_HI = (CLAMP_STUDIO != 0) ? C_MAX : 255;

    // Whole pipeline moves together; a stalled output freezes every stage.
    logic adv;
    assign adv   = ~vld_o | rdy_i;
    assign rdy_o = adv;

    sum_t sy_c, sb_c, sr_c;

    rgb2ycbcr_dot #(.KA(K_YR), .KB(K_YG), .KC(K_YB)) u_dot_y (
        .a(r), .b(g), .c(b), .sum(sy_c)
    );
    rgb2ycbcr_dot #(.KA(K_BR), .KB(K_BG), .KC(K_BB)) u_dot_b (
        .a(r), .b(g), .c(b), .sum(sb_c)
    );
    rgb2ycbcr_dot #(.KA(K_RR), .KB(K_RG), .KC(K_RB)) u_dot_r (
        .a(r), .b(g), .c(b), .sum(sr_c)
    );

    logic v1;
    sum_t s1_sy, s1_sb, s1_sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1    <= 1'b0;
            s1_sy <= '0;
            s1_sb <= '0;
            s1_sr <= '0;
        end else if (adv) begin
            v1    <= vld_i;
            s1_sy <= sy_c;
            s1_sb <= sb_c;
            s1_sr <= sr_c;
        end
    end

    // Floor-divide by 256, add offsets, then saturate to the selected swing.
    ext_t y_full, cb_full, cr_full;
    ycc_t sat_c;

    assign y_full   = EXT_W'(Y_OFF) + EXT_W'(s1_sy >>> 8);
    assign cb_full  = EXT_W'(C_OFF) + EXT_W'(s1_sb >>> 8);
    assign cr_full  = EXT_W'(C_OFF) + EXT_W'(s1_sr >>> 8);
    assign sat_c.y  = sat(y_full, Y_LO, Y_HI);
    assign sat_c.cb = sat(cb_full, C_LO, C_HI);
    assign sat_c.cr = sat(cr_full, C_LO, C_HI);

`ifdef CHROMA_422_EN
    logic             ph, pix_ph, s1_ph;
    logic [PIX_W-1:0] cb0, cr0;
    logic [PIX_W-1:0] cb_avg_c, cr_avg_c;

    // Start-of-line forces the pixel onto the even (held) phase.
    assign pix_ph = sol_i ? 1'b0 : ph;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph    <= 1'b0;
            s1_ph <= 1'b0;
        end else if (adv) begin
            s1_ph <= pix_ph;
            if (vld_i) ph <= ~pix_ph;
        end
    end

    assign cb_avg_c = PIX_W'(({1'b0, cb0} + {1'b0, sat_c.cb} + 9'd1) >> 1);
    assign cr_avg_c = PIX_W'(({1'b0, cr0} + {1'b0, sat_c.cr} + 9'd1) >> 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_o   <= 1'b0;
            c_vld_o <= 1'b0;
            y       <= '0;
            cb      <= '0;
            cr      <= '0;
            cb0     <= '0;
            cr0     <= '0;
        end else if (adv) begin
            vld_o <= v1;
            y     <= sat_c.y;
            if (s1_ph) begin
                cb      <= cb_avg_c;
                cr      <= cr_avg_c;
                c_vld_o <= v1;
            end else begin
                cb      <= '0;
                cr      <= '0;
                c_vld_o <= 1'b0;
                if (v1) begin
                    cb0 <= sat_c.cb;
                    cr0 <= sat_c.cr;
                end
            end
        end
    end
`else
    logic unused_sol;
    assign unused_sol = sol_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_o   <= 1'b0;
            c_vld_o <= 1'b0;
            y       <= '0;
            cb      <= '0;
            cr      <= '0;
        end else if (adv) begin
            vld_o   <= v1;
            c_vld_o <= v1;
            y       <= sat_c.y;
            cb      <= sat_c.cb;
            cr      <= sat_c.cr;
        end
    end
`endif

endmodule

// File: tb/tb_rgb2ycbcr_pipe.sv
// Self-checking bench for rgb2ycbcr_pipe: vector table, directed corners and
// randomized traffic against a plain-arithmetic colour-conversion model.
module tb_rgb2ycbcr_pipe;

    logic       clk, rstn;
    logic [7:0] r, g, b;
    logic       sol_i, vld_i, rdy_i;
    logic       rdy_o, c_vld_o, vld_o;
    logic [7:0] y, cb, cr;
    logic       rdy_s, c_vld_s, vld_s;
    logic [7:0] ys, cbs, crs;

    rgb2ycbcr_pipe #(.CLAMP_STUDIO(0)) dut (
        .clk(clk), .rstn(rstn), .r(r), .g(g), .b(b), .sol_i(sol_i),
        .vld_i(vld_i), .rdy_o(rdy_o), .y(y), .cb(cb), .cr(cr),
        .c_vld_o(c_vld_o), .vld_o(vld_o), .rdy_i(rdy_i)
    );

    rgb2ycbcr_pipe #(.CLAMP_STUDIO(1)) dut_s (
        .clk(clk), .rstn(rstn), .r(r), .g(g), .b(b), .sol_i(sol_i),
        .vld_i(vld_i), .rdy_o(rdy_s), .y(ys), .cb(cbs), .cr(crs),
        .c_vld_o(c_vld_s), .vld_o(vld_s), .rdy_i(rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y0, cb0, cr0;
        int y1, cb1, cr1;
        int cv;
    } exp_t;

    typedef struct {
        int r, g, b;
        int ey, ecb, ecr;
    } vec_t;

    exp_t q[$];
    vec_t vecs[5];
    int   errors = 0;
    int   checks = 0;
    int   delivered = 0;
    int   mph = 0;
    int   hb0 = 0, hr0 = 0, hb1 = 0, hr1 = 0;
    bit   grey_mode = 1'b0;

    function automatic int fdiv256(input int a);
        int qq;
        qq = a / 256;
        if (a < 0 && (a % 256) != 0) qq = qq - 1;
        return qq;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int rr, input int gg, input int bb,
                         input bit v, input bit s, input bit rd);
        r     = 8'(rr);
        g     = 8'(gg);
        b     = 8'(bb);
        vld_i = v;
        sol_i = s;
        rdy_i = rd;
    endtask

    // Reference: BT.601 integer formulas, floor division, clamp, optional pairing.
    task automatic push_model(input int rr, input int gg, input int bb, input bit s);
        exp_t e;
        int   yf, cbf, crf, ph;
        yf    = 16  + fdiv256(66 * rr + 129 * gg + 25 * bb + 128);
        cbf   = 128 + fdiv256(-38 * rr - 74 * gg + 112 * bb + 128);
        crf   = 128 + fdiv256(112 * rr - 94 * gg - 18 * bb + 128);
        e.y0  = clampi(yf, 0, 255);
        e.cb0 = clampi(cbf, 0, 255);
        e.cr0 = clampi(crf, 0, 255);
        e.y1  = clampi(yf, 16, 235);
        e.cb1 = clampi(cbf, 16, 240);
        e.cr1 = clampi(crf, 16, 240);
        e.cv  = 1;
`ifdef CHROMA_422_EN
        ph = s ? 0 : mph;
        if (ph == 0) begin
            hb0 = e.cb0; hr0 = e.cr0; hb1 = e.cb1; hr1 = e.cr1;
            e.cb0 = 0; e.cr0 = 0; e.cb1 = 0; e.cr1 = 0; e.cv = 0;
        end else begin
            e.cb0 = (hb0 + e.cb0 + 1) / 2;
            e.cr0 = (hr0 + e.cr0 + 1) / 2;
            e.cb1 = (hb1 + e.cb1 + 1) / 2;
            e.cr1 = (hr1 + e.cr1 + 1) / 2;
        end
        mph = 1 - ph;
`else
        ph = 0;
        mph = ph;
`endif
        q.push_back(e);
    endtask

    // Sample between edges, score any output/input handshake, advance one clock.
    task automatic cycle();
        exp_t e;
        #1;
        check("rdy_rule", int'(rdy_o), int'(!vld_o || rdy_i));
        check("rdy_rule_s", int'(rdy_s), int'(!vld_s || rdy_i));
        if (!vld_o) check("cvld_bubble", int'(c_vld_o), 0);
        if (vld_o && rdy_i) begin
            if (q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = q.pop_front();
                delivered++;
                check("y", int'(y), e.y0);
                check("cb", int'(cb), e.cb0);
                check("cr", int'(cr), e.cr0);
                check("c_vld", int'(c_vld_o), e.cv);
                check("vld_s", int'(vld_s), 1);
                check("y_s", int'(ys), e.y1);
                check("cb_s", int'(cbs), e.cb1);
                check("cr_s", int'(crs), e.cr1);
                if (grey_mode) begin
                    check("grey_y_range", int'(ys >= 8'd16 && ys <= 8'd235), 1);
                    if (c_vld_s) begin
                        check("grey_cb", int'(cbs), 128);
                        check("grey_cr", int'(crs), 128);
                    end
                end
            end
        end
        if (vld_i && rdy_o) push_model(int'(r), int'(g), int'(b), sol_i);
        @(negedge clk);
    endtask

    task automatic drain();
        drive(0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle();
        check("drain_empty", q.size(), 0);
    endtask

`ifdef CHROMA_422_EN
    localparam int PAIR_CV1 = 0;
    localparam int PAIR_CB2 = 165;
    localparam int PAIR_CR2 = 175;
`else
    localparam int PAIR_CV1 = 1;
    localparam int PAIR_CB2 = 240;
    localparam int PAIR_CR2 = 110;
`endif

    initial begin
        int ocv[5];
        int n, d0;
        bit stall;
        int px[6][3];

        vecs[0] = '{r: 0,   g: 0,   b: 0,   ey: 16,  ecb: 128, ecr: 128};
        vecs[1] = '{r: 255, g: 255, b: 255, ey: 235, ecb: 128, ecr: 128};
        vecs[2] = '{r: 255, g: 0,   b: 0,   ey: 82,  ecb: 90,  ecr: 240};
        vecs[3] = '{r: 0,   g: 0,   b: 255, ey: 41,  ecb: 240, ecr: 110};
        vecs[4] = '{r: 0,   g: 255, b: 0,   ey: 144, ecb: 54,  ecr: 34};
`ifdef CHROMA_422_EN
        ocv = '{0, 1, 0, 0, 1};
`else
        ocv = '{1, 1, 1, 1, 1};
`endif

        // Reset values.
        rstn = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_vld", int'(vld_o), 0);
        check("rst_cvld", int'(c_vld_o), 0);
        check("rst_y", int'(y), 0);
        check("rst_cb", int'(cb), 0);
        check("rst_cr", int'(cr), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rdy_after_rst", int'(rdy_o), 1);
        @(negedge clk);

        // Vector table, back-to-back, with 2-cycle latency.
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(vecs[i].r, vecs[i].g, vecs[i].b, 1'b1, 1'b1, 1'b1);
            else       drive(0, 0, 0, 1'b0, 1'b0, 1'b1);
            #1;
            if (i < 2) begin
                check("latency_vld_low", int'(vld_o), 0);
            end else begin
                check("tbl_vld", int'(vld_o), 1);
                check("tbl_y", int'(y), vecs[i-2].ey);
`ifndef CHROMA_422_EN
                check("tbl_cb", int'(cb), vecs[i-2].ecb);
                check("tbl_cr", int'(cr), vecs[i-2].ecr);
`endif
            end
            cycle();
        end
        drain();

        // Six-pixel stream with a three-cycle downstream stall.
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 3; j++) px[i][j] = int'($urandom_range(0, 255));
        n  = 0;
        d0 = delivered;
        for (int k = 0; k < 14; k++) begin
            stall = (k >= 3 && k <= 5);
            if (n < 6) drive(px[n][0], px[n][1], px[n][2], 1'b1, n == 0, !stall);
            else       drive(0, 0, 0, 1'b0, 1'b0, !stall);
            #1;
            if (stall) begin
                check("stall_rdy_o", int'(rdy_o), 0);
                check("stall_vld_o", int'(vld_o), 1);
                if (q.size() > 0) begin
                    check("stall_y_hold", int'(y), q[0].y0);
                    check("stall_cb_hold", int'(cb), q[0].cb0);
                    check("stall_cr_hold", int'(cr), q[0].cr0);
                end else begin
                    check("stall_queue_nonempty", 0, 1);
                end
            end
            if (vld_i && rdy_o) begin
                cycle();
                n++;
            end else begin
                cycle();
            end
        end
        check("stall_delivered", delivered - d0, 6);
        drain();

        // Chroma pair (red, blue) with start-of-line on the first pixel.
        drive(255, 0, 0, 1'b1, 1'b1, 1'b1);
        cycle();
        drive(0, 0, 255, 1'b1, 1'b0, 1'b1);
        cycle();
        drive(0, 0, 0, 1'b0, 1'b0, 1'b1);
        #1;
        check("pair1_vld", int'(vld_o), 1);
        check("pair1_cvld", int'(c_vld_o), PAIR_CV1);
        cycle();
        #1;
        check("pair2_cvld", int'(c_vld_o), 1);
        check("pair2_cb", int'(cb), PAIR_CB2);
        check("pair2_cr", int'(cr), PAIR_CR2);
        cycle();
        drain();

        // Odd-length line, then a new line: phase restarts.
        for (int k = 0; k < 7; k++) begin
            if (k < 5) drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                             int'($urandom_range(0, 255)), 1'b1, (k == 0 || k == 3), 1'b1);
            else       drive(0, 0, 0, 1'b0, 1'b0, 1'b1);
            #1;
            if (k >= 2) check("line_cvld", int'(c_vld_o), ocv[k-2]);
            cycle();
        end
        drain();

        // Grey sweep on the studio-clamped instance.
        grey_mode = 1'b1;
        for (int v = 0; v < 256; v++) begin
            drive(v, v, v, 1'b1, v == 0, 1'b1);
            cycle();
        end
        drain();
        grey_mode = 1'b0;

        // Randomized traffic with random back-pressure and line starts.
        for (int k = 0; k < 400; k++) begin
            drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
            cycle();
        end
        drain();

        // Reset while the output is valid and stalled.
        for (int k = 0; k < 3; k++) begin
            drive(int'($urandom_range(0, 255)), 7, 9, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        #1;
        check("pre_rst_vld", int'(vld_o), 1);
        check("pre_rst_rdy", int'(rdy_o), 0);
        rstn = 1'b0;
        #1;
        check("async_rst_vld", int'(vld_o), 0);
        check("async_rst_cvld", int'(c_vld_o), 0);
        check("async_rst_vld_s", int'(vld_s), 0);
        q.delete();
        mph = 0; hb0 = 0; hr0 = 0; hb1 = 0; hr1 = 0;
        drive(0, 0, 0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("no_stale_out", int'(vld_o), 0);
            cycle();
        end
        drive(200, 100, 50, 1'b1, 1'b0, 1'b1);
        cycle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
